// File: rtl/aes_input_stage.sv
// AES-128 input stage: packs 32-bit words into key/plaintext blocks and emits round-0 AddRoundKey.
// Optional AES_BLOCK_COUNT_EN adds o_block_count, a wrapping count of emitted blocks.
module aes_input_stage #(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_valid,
  input  logic               i_sel,
  input  logic [31:0]        i_word,
  output logic               o_ready,
  output logic               o_tx_en,
  output logic [127:0]       o_state,
  output logic [127:0]       o_round_key,
  output logic               o_key_ok,
  output logic               o_err
`ifdef AES_BLOCK_COUNT_EN
  ,
  output logic [COUNT_W-1:0] o_block_count
`endif
);

  logic [127:0] key_q, key_d;
  logic [127:0] data_q, data_d;
  logic [1:0]   kcnt_q, kcnt_d;
  logic [1:0]   dcnt_q, dcnt_d;
  logic         key_ok_q, key_ok_d;
  logic         hold_q, hold_d;
  logic         err_q, err_d;
  logic         tx_en_q;
  logic [127:0] state_q;
  logic [127:0] round_key_q;

  logic         ready_s;
  logic         accept_s;
  logic         emit_s;
  logic [127:0] emit_state_s;
  logic [127:0] emit_key_s;

  // A held block only waits for the key; key words must keep flowing to release it.
  assign ready_s  = !(hold_q && (i_sel == 1'b0));
  assign accept_s = i_valid && ready_s;

  // Next-state for word assembly, key status, hold, error and the emit decision.
  always_comb begin
    key_d        = key_q;
    data_d       = data_q;
    kcnt_d       = kcnt_q;
    dcnt_d       = dcnt_q;
    key_ok_d     = key_ok_q;
    hold_d       = hold_q;
    err_d        = err_q;
    emit_s       = 1'b0;
    emit_state_s = 128'd0;
    emit_key_s   = 128'd0;
    if (accept_s) begin
      if (i_sel) begin
        key_d[127 - 32*kcnt_q -: 32] = i_word;
        kcnt_d = kcnt_q + 2'd1;
        if (dcnt_q != 2'd0) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (kcnt_q == 2'd3) begin
          key_ok_d = 1'b1;
          if (hold_q) begin
            // Completed key goes straight to the held block; key_q is not updated until this edge.
            emit_s       = 1'b1;
            emit_key_s   = {key_q[127:32], i_word};
            emit_state_s = data_q ^ {key_q[127:32], i_word};
            hold_d       = 1'b0;
          end else begin
            hold_d = hold_q;
          end
        end else if (kcnt_q == 2'd0) begin
          key_ok_d = 1'b0;
        end else begin
          key_ok_d = key_ok_q;
        end
      end else begin
        data_d[127 - 32*dcnt_q -: 32] = i_word;
        dcnt_d = dcnt_q + 2'd1;
        if (kcnt_q != 2'd0) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (dcnt_q == 2'd3) begin
          if (key_ok_q && (kcnt_q == 2'd0)) begin
            emit_s       = 1'b1;
            emit_key_s   = key_q;
            emit_state_s = {data_q[127:32], i_word} ^ key_q;
          end else begin
            hold_d = 1'b1;
          end
        end else begin
          hold_d = hold_q;
        end
      end
    end else begin
      emit_s = 1'b0;
    end
  end

  // State registers and the registered one-cycle output triple.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_q       <= 128'd0;
      data_q      <= 128'd0;
      kcnt_q      <= 2'd0;
      dcnt_q      <= 2'd0;
      key_ok_q    <= 1'b0;
      hold_q      <= 1'b0;
      err_q       <= 1'b0;
      tx_en_q     <= 1'b0;
      state_q     <= 128'd0;
      round_key_q <= 128'd0;
    end else begin
      key_q       <= key_d;
      data_q      <= data_d;
      kcnt_q      <= kcnt_d;
      dcnt_q      <= dcnt_d;
      key_ok_q    <= key_ok_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
      tx_en_q     <= emit_s;
      state_q     <= emit_state_s;
      round_key_q <= emit_key_s;
    end
  end

`ifdef AES_BLOCK_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  // Emitted-block counter, wraps naturally at its width.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= {COUNT_W{1'b0}};
    end else if (emit_s) begin
      count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_q <= count_q;
    end
  end

  assign o_block_count = count_q;
`else
  localparam int unused_count_w = COUNT_W;
`endif

  assign o_ready     = ready_s;
  assign o_tx_en     = tx_en_q;
  assign o_state     = state_q;
  assign o_round_key = round_key_q;
  assign o_key_ok    = key_ok_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_aes_input_stage.sv
// Directed bench for aes_input_stage: FIPS-197 round-0 vectors, hold, back-to-back, reload, reset.
// Define AES_BLOCK_COUNT_EN to also exercise o_block_count with COUNT_W=2.
module tb_aes_input_stage;

  logic         clock = 1'b0;
  logic         reset;
  logic         i_valid;
  logic         i_sel;
  logic [31:0]  i_word;
  logic         o_ready;
  logic         o_tx_en;
  logic [127:0] o_state;
  logic [127:0] o_round_key;
  logic         o_key_ok;
  logic         o_err;
`ifdef AES_BLOCK_COUNT_EN
  logic [1:0]   o_block_count;
`endif

  int checks = 0;
  int fails  = 0;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B = 128'hffffffff00000000123456789abcdef0;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT_AA = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] CT_BA = 128'hffefdfcfbfaf9f8f7f6f5f4f3f2f1f0f;
  localparam logic [127:0] CT_AB = 128'hffeeddcc445566779aadfcc35661300f;

  aes_input_stage #(.COUNT_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_sel       (i_sel),
    .i_word      (i_word),
    .o_ready     (o_ready),
    .o_tx_en     (o_tx_en),
    .o_state     (o_state),
    .o_round_key (o_round_key),
    .o_key_ok    (o_key_ok),
    .o_err       (o_err)
`ifdef AES_BLOCK_COUNT_EN
    ,
    .o_block_count (o_block_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic send_word(input logic sel, input logic [31:0] w);
    i_valid = 1'b1;
    i_sel   = sel;
    i_word  = w;
    @(posedge clock);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send_block(input logic sel, input logic [127:0] v);
    for (int w = 0; w < 4; w++) send_word(sel, v[127 - 32*w -: 32]);
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    i_valid = 1'b0;
    i_sel   = 1'b0;
    i_word  = 32'd0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (o_tx_en !== 1'b0) begin fails++; $display("FAIL reset_tx_en: got %b want 0", o_tx_en); end
    checks++; if (o_state !== 128'd0) begin fails++; $display("FAIL reset_state: got %h want 0", o_state); end
    checks++; if (o_round_key !== 128'd0) begin fails++; $display("FAIL reset_round_key: got %h want 0", o_round_key); end
    checks++; if (o_key_ok !== 1'b0) begin fails++; $display("FAIL reset_key_ok: got %b want 0", o_key_ok); end
    checks++; if (o_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", o_err); end
    checks++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", o_ready); end
`ifdef AES_BLOCK_COUNT_EN
    checks++; if (o_block_count !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", o_block_count); end
`endif
  endtask

  task automatic test_fips();
    send_block(1'b1, KEY_A);
    checks++; if (o_key_ok !== 1'b1) begin fails++; $display("FAIL fips_key_ok: got %b want 1", o_key_ok); end
    checks++; if (o_tx_en !== 1'b0) begin fails++; $display("FAIL fips_no_emit_on_key: got %b want 0", o_tx_en); end
    send_block(1'b0, PT_A);
    checks++; if (o_tx_en !== 1'b1) begin fails++; $display("FAIL fips_tx_en: got %b want 1", o_tx_en); end
    checks++; if (o_state !== CT_AA) begin fails++; $display("FAIL fips_state: got %h want %h", o_state, CT_AA); end
    checks++; if (o_round_key !== KEY_A) begin fails++; $display("FAIL fips_round_key: got %h want %h", o_round_key, KEY_A); end
    @(posedge clock); #1;
    checks++; if (o_tx_en !== 1'b0) begin fails++; $display("FAIL fips_tx_en_drop: got %b want 0", o_tx_en); end
    checks++; if (o_state !== 128'd0) begin fails++; $display("FAIL fips_state_zero: got %h want 0", o_state); end
    checks++; if (o_round_key !== 128'd0) begin fails++; $display("FAIL fips_key_zero: got %h want 0", o_round_key); end
  endtask

  task automatic test_hold();
    apply_reset();
    send_block(1'b0, PT_A);
    checks++; if (o_tx_en !== 1'b0) begin fails++; $display("FAIL hold_no_emit: got %b want 0", o_tx_en); end
    checks++; if (o_ready !== 1'b0) begin fails++; $display("FAIL hold_ready_data: got %b want 0", o_ready); end
    // Stalled data word must not overwrite the held block.
    i_valid = 1'b1; i_sel = 1'b0; i_word = 32'hdeadbeef;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (o_tx_en !== 1'b0) begin fails++; $display("FAIL hold_stall_no_emit: got %b want 0", o_tx_en); end
    i_sel = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin fails++; $display("FAIL hold_ready_key: got %b want 1", o_ready); end
    i_valid = 1'b0;
    send_block(1'b1, KEY_A);
    checks++; if (o_tx_en !== 1'b1) begin fails++; $display("FAIL hold_release_tx_en: got %b want 1", o_tx_en); end
    checks++; if (o_state !== CT_AA) begin fails++; $display("FAIL hold_release_state: got %h want %h", o_state, CT_AA); end
    checks++; if (o_round_key !== KEY_A) begin fails++; $display("FAIL hold_release_key: got %h want %h", o_round_key, KEY_A); end
    i_sel = 1'b0;
    @(posedge clock); #1;
    checks++; if (o_tx_en !== 1'b0) begin fails++; $display("FAIL hold_release_single: got %b want 0", o_tx_en); end
    checks++; if (o_ready !== 1'b1) begin fails++; $display("FAIL hold_cleared_ready: got %b want 1", o_ready); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blks [3];
    logic [127:0] exps [3];
    blks[0] = PT_A;  exps[0] = CT_AA;
    blks[1] = PT_B;  exps[1] = CT_BA;
    blks[2] = 128'd0; exps[2] = KEY_A;
    for (int b = 0; b < 3; b++) begin
      for (int w = 0; w < 4; w++) begin
        send_word(1'b0, blks[b][127 - 32*w -: 32]);
        checks++; if (o_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready blk%0d beat%0d: got %b want 1", b, w, o_ready); end
        checks++; if (o_tx_en !== (w == 3)) begin fails++; $display("FAIL b2b_tx_en blk%0d beat%0d: got %b want %b", b, w, o_tx_en, (w == 3)); end
        if (w == 3) begin
          checks++; if (o_state !== exps[b]) begin fails++; $display("FAIL b2b_state blk%0d: got %h want %h", b, o_state, exps[b]); end
        end
      end
    end
  endtask

  task automatic test_reload();
    apply_reset();
    send_block(1'b1, KEY_A);
    send_word(1'b0, PT_A[127:96]);
    send_word(1'b0, PT_A[95:64]);
    send_word(1'b1, KEY_B[127:96]);
    send_word(1'b1, KEY_B[95:64]);
    checks++; if (o_err !== 1'b1) begin fails++; $display("FAIL reload_err: got %b want 1", o_err); end
    checks++; if (o_key_ok !== 1'b0) begin fails++; $display("FAIL reload_key_ok: got %b want 0", o_key_ok); end
    send_word(1'b0, PT_A[63:32]);
    send_word(1'b0, PT_A[31:0]);
    checks++; if (o_tx_en !== 1'b0) begin fails++; $display("FAIL reload_held_no_emit: got %b want 0", o_tx_en); end
    checks++; if (o_ready !== 1'b0) begin fails++; $display("FAIL reload_held_ready: got %b want 0", o_ready); end
    send_word(1'b1, KEY_B[63:32]);
    send_word(1'b1, KEY_B[31:0]);
    checks++; if (o_tx_en !== 1'b1) begin fails++; $display("FAIL reload_release_tx_en: got %b want 1", o_tx_en); end
    checks++; if (o_state !== CT_AB) begin fails++; $display("FAIL reload_release_state: got %h want %h", o_state, CT_AB); end
    checks++; if (o_round_key !== KEY_B) begin fails++; $display("FAIL reload_release_key: got %h want %h", o_round_key, KEY_B); end
    send_block(1'b0, PT_A);
    checks++; if (o_tx_en !== 1'b1) begin fails++; $display("FAIL reload_next_tx_en: got %b want 1", o_tx_en); end
    checks++; if (o_state !== CT_AB) begin fails++; $display("FAIL reload_next_state: got %h want %h", o_state, CT_AB); end
    checks++; if (o_err !== 1'b1) begin fails++; $display("FAIL reload_err_sticky: got %b want 1", o_err); end
  endtask

  task automatic test_reset_mid();
    send_block(1'b1, KEY_A);
    send_word(1'b0, PT_A[127:96]);
    send_word(1'b0, PT_A[95:64]);
    send_word(1'b0, PT_A[63:32]);
    apply_reset();
    checks++; if (o_tx_en !== 1'b0) begin fails++; $display("FAIL midrst_tx_en: got %b want 0", o_tx_en); end
    checks++; if (o_key_ok !== 1'b0) begin fails++; $display("FAIL midrst_key_ok: got %b want 0", o_key_ok); end
    checks++; if (o_err !== 1'b0) begin fails++; $display("FAIL midrst_err: got %b want 0", o_err); end
    send_block(1'b0, PT_A);
    checks++; if (o_tx_en !== 1'b0) begin fails++; $display("FAIL midrst_hold_no_emit: got %b want 0", o_tx_en); end
    checks++; if (o_ready !== 1'b0) begin fails++; $display("FAIL midrst_hold_ready: got %b want 0", o_ready); end
  endtask

`ifdef AES_BLOCK_COUNT_EN
  task automatic test_block_count();
    apply_reset();
    send_block(1'b1, KEY_A);
    for (int b = 0; b < 5; b++) send_block(1'b0, PT_A);
    checks++; if (o_block_count !== 2'd1) begin fails++; $display("FAIL count_wrap: got %0d want 1", o_block_count); end
  endtask
`endif

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_sel   = 1'b0;
    i_word  = 32'd0;
    test_reset();
    test_fips();
    test_hold();
    test_back_to_back();
    test_reload();
    test_reset_mid();
`ifdef AES_BLOCK_COUNT_EN
    test_block_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
